// File: rtl/operand_forward_ctrl_pkg.sv
// Shared constants, shadow-entry layout and FSM codes for the EX-stage operand forwarding controller.
package operand_forward_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int SEL_W      = 3;

   typedef logic [SEL_W-1:0]      sel_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam sel_t      SEL_RF         = 3'd0;
   localparam sel_t      SEL_EXMEM_ALU  = 3'd1;
   localparam sel_t      SEL_MEMWB_ALU  = 3'd2;
   localparam sel_t      SEL_MEMWB_LOAD = 3'd3;
   localparam sel_t      SEL_RETIRED    = 3'd4;
   localparam reg_addr_t REG_ZERO       = 5'd0;

   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      logic      wen;
      logic      is_load;
   } shadow_t;

   localparam shadow_t SHADOW_BUBBLE = '{valid: 1'b0, rd: 5'd0, wen: 1'b0, is_load: 1'b0};

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_FROZEN  = 2'd2
   } fsm_state_t;

   function automatic logic shadow_hit(input shadow_t entry, input reg_addr_t rs);
      return entry.valid & entry.wen & (entry.rd == rs);
   endfunction

endpackage

// File: rtl/operand_forward_ctrl_if.sv
// ID-stage request, control and forwarding-select bundle; counters exist only with OPERAND_FORWARD_STATS_EN.
interface operand_forward_ctrl_if;
   import operand_forward_ctrl_pkg::*;

   logic      ID_VALID;
   reg_addr_t ID_RS1;
   reg_addr_t ID_RS2;
   logic      ID_RS1_USED;
   logic      ID_RS2_USED;
   reg_addr_t ID_RD;
   logic      ID_WRITE_EN;
   logic      ID_IS_LOAD;
   logic      BUSY;
   logic      FLUSH;
   sel_t      FWD_SEL_A;
   sel_t      FWD_SEL_B;
   logic      STALL;
`ifdef OPERAND_FORWARD_STATS_EN
   logic [31:0] STALL_COUNT;
   logic [31:0] FWD_COUNT;
`endif

   modport master (
      output ID_VALID, ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED,
      output ID_RD, ID_WRITE_EN, ID_IS_LOAD, BUSY, FLUSH,
      input  FWD_SEL_A, FWD_SEL_B, STALL
`ifdef OPERAND_FORWARD_STATS_EN
      , input STALL_COUNT, FWD_COUNT
`endif
   );

   modport slave (
      input  ID_VALID, ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED,
      input  ID_RD, ID_WRITE_EN, ID_IS_LOAD, BUSY, FLUSH,
      output FWD_SEL_A, FWD_SEL_B, STALL
`ifdef OPERAND_FORWARD_STATS_EN
      , output STALL_COUNT, FWD_COUNT
`endif
   );

endinterface

// File: rtl/operand_forward_ctrl_fwd_select_logic.sv
// Per-operand select, youngest producer first; load_hit flags a load in EX that this source needs.
module fwd_select_logic
   import operand_forward_ctrl_pkg::*;
(
   input  reg_addr_t rs,
   input  logic      used,
   input  shadow_t   sh_ex,
   input  shadow_t   sh_mem,
   input  shadow_t   sh_wb,
   output sel_t      sel,
   output logic      load_hit
);

   // Priority chain; the retired slot never forwards because the register file already holds it.
   always_comb begin
      sel      = SEL_RF;
      load_hit = 1'b0;
      if (!used || (rs == REG_ZERO)) begin
         sel = SEL_RF;
      end else begin
         load_hit = shadow_hit(sh_ex, rs) & sh_ex.is_load;
         if (shadow_hit(sh_ex, rs) && !sh_ex.is_load) begin
            sel = SEL_EXMEM_ALU;
         end else if (shadow_hit(sh_mem, rs)) begin
            sel = sh_mem.is_load ? SEL_MEMWB_LOAD : SEL_MEMWB_ALU;
         end else if (shadow_hit(sh_wb, rs)) begin
            sel = SEL_RETIRED;
         end else begin
            sel = SEL_RF;
         end
      end
   end

endmodule

// File: rtl/operand_forward_ctrl.sv
// EX-operand forwarding and load-use hazard controller.
// Optional OPERAND_FORWARD_STATS_EN adds STALL_COUNT / FWD_COUNT.
module operand_forward_ctrl
   import operand_forward_ctrl_pkg::*;
(
   input logic                   CLK,
   input logic                   RESET,
   operand_forward_ctrl_if.slave bus
);

   shadow_t    sh_ex_q, sh_ex_d, sh_mem_q, sh_mem_d, sh_wb_q, sh_wb_d, sh_ret_q, sh_ret_d;
   sel_t       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   sel_t       sel_a_s, sel_b_s;
   logic       load_hit_a_s, load_hit_b_s;
   logic       hazard_s, stall_s;
   shadow_t    id_entry_s;
   fsm_state_t state_q, state_d;

   fwd_select_logic u_sel_a (
      .rs(bus.ID_RS1), .used(bus.ID_RS1_USED),
      .sh_ex(sh_ex_q), .sh_mem(sh_mem_q), .sh_wb(sh_wb_q),
      .sel(sel_a_s), .load_hit(load_hit_a_s)
   );

   fwd_select_logic u_sel_b (
      .rs(bus.ID_RS2), .used(bus.ID_RS2_USED),
      .sh_ex(sh_ex_q), .sh_mem(sh_mem_q), .sh_wb(sh_wb_q),
      .sel(sel_b_s), .load_hit(load_hit_b_s)
   );

   // A flushed hazard never stalls: the consumer is being killed anyway.
   assign hazard_s = bus.ID_VALID & (load_hit_a_s | load_hit_b_s);
   assign stall_s  = hazard_s & ~bus.BUSY & ~bus.FLUSH & ~RESET;

   always_comb begin
      id_entry_s = SHADOW_BUBBLE;
      if (bus.ID_VALID) begin
         id_entry_s = '{valid: 1'b1, rd: bus.ID_RD, wen: bus.ID_WRITE_EN, is_load: bus.ID_IS_LOAD};
      end else begin
         id_entry_s = SHADOW_BUBBLE;
      end
   end

   always_comb begin
      sh_ex_d  = sh_ex_q;
      sh_mem_d = sh_mem_q;
      sh_wb_d  = sh_wb_q;
      sh_ret_d = sh_ret_q;
      sel_a_d  = sel_a_q;
      sel_b_d  = sel_b_q;
      if (RESET) begin
         sh_ex_d  = SHADOW_BUBBLE;
         sh_mem_d = SHADOW_BUBBLE;
         sh_wb_d  = SHADOW_BUBBLE;
         sh_ret_d = SHADOW_BUBBLE;
         sel_a_d  = SEL_RF;
         sel_b_d  = SEL_RF;
      end else if (bus.BUSY) begin
         sh_ex_d  = sh_ex_q;
         sel_a_d  = sel_a_q;
         sel_b_d  = sel_b_q;
      end else begin
         sh_mem_d = sh_ex_q;
         sh_wb_d  = sh_mem_q;
         sh_ret_d = sh_wb_q;
         if (bus.FLUSH || hazard_s || !bus.ID_VALID) begin
            sh_ex_d = SHADOW_BUBBLE;
            sel_a_d = SEL_RF;
            sel_b_d = SEL_RF;
         end else begin
            sh_ex_d = id_entry_s;
            sel_a_d = sel_a_s;
            sel_b_d = sel_b_s;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (RESET) begin
         state_d = ST_RUN;
      end else if (bus.BUSY) begin
         state_d = ST_FROZEN;
      end else begin
         case (state_q)
            ST_RUN:     state_d = stall_s ? ST_LDSTALL : ST_RUN;
            ST_LDSTALL: state_d = ST_RUN;
            ST_FROZEN:  state_d = ST_RUN;
            default:    state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      sh_ex_q  <= sh_ex_d;
      sh_mem_q <= sh_mem_d;
      sh_wb_q  <= sh_wb_d;
      sh_ret_q <= sh_ret_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      state_q  <= state_d;
   end

   assign bus.FWD_SEL_A = sel_a_q;
   assign bus.FWD_SEL_B = sel_b_q;
   assign bus.STALL     = stall_s;

`ifdef OPERAND_FORWARD_STATS_EN
   logic [31:0] stall_count_q, stall_count_d, fwd_count_q, fwd_count_d;
   logic        normal_adv_s;

   assign normal_adv_s = ~RESET & ~bus.BUSY & ~bus.FLUSH & ~hazard_s & bus.ID_VALID;

   always_comb begin
      stall_count_d = stall_count_q;
      fwd_count_d   = fwd_count_q;
      if (RESET) begin
         stall_count_d = 32'd0;
         fwd_count_d   = 32'd0;
      end else begin
         if (stall_s) begin
            stall_count_d = stall_count_q + 32'd1;
         end else begin
            stall_count_d = stall_count_q;
         end
         if (normal_adv_s && ((sel_a_s != SEL_RF) || (sel_b_s != SEL_RF))) begin
            fwd_count_d = fwd_count_q + 32'd1;
         end else begin
            fwd_count_d = fwd_count_q;
         end
      end
   end

   always_ff @(posedge CLK) begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
   end

   assign bus.STALL_COUNT = stall_count_q;
   assign bus.FWD_COUNT   = fwd_count_q;
`endif

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed self-checking bench for operand_forward_ctrl; stats checks run when OPERAND_FORWARD_STATS_EN is defined.
module tb_operand_forward_ctrl;
   import operand_forward_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   operand_forward_ctrl_if bus ();

   operand_forward_ctrl dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld);
      bus.ID_VALID    = v;
      bus.ID_RS1      = rs1;
      bus.ID_RS2      = rs2;
      bus.ID_RS1_USED = u1;
      bus.ID_RS2_USED = u2;
      bus.ID_RD       = rd;
      bus.ID_WRITE_EN = we;
      bus.ID_IS_LOAD  = ld;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      nop();
      bus.BUSY  = 1'b0;
      bus.FLUSH = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL reset_sel_a: got %0d expected 0", bus.FWD_SEL_A); else n_pass++;
      n_total++; if (bus.FWD_SEL_B !== 3'd0) $display("FAIL reset_sel_b: got %0d expected 0", bus.FWD_SEL_B); else n_pass++;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", bus.STALL); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      #1;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL b2b_stall: got %0b expected 0", bus.STALL); else n_pass++;
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd1) $display("FAIL b2b_sel_a: got %0d expected 1", bus.FWD_SEL_A); else n_pass++;
      n_total++; if (bus.FWD_SEL_B !== 3'd0) $display("FAIL b2b_sel_b: got %0d expected 0", bus.FWD_SEL_B); else n_pass++;
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      #1;
      n_total++; if (bus.STALL !== 1'b1) $display("FAIL lu_stall_set: got %0b expected 1", bus.STALL); else n_pass++;
      tick();
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL lu_stall_one_cycle: got %0b expected 0", bus.STALL); else n_pass++;
      n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL lu_bubble_sel_a: got %0d expected 0", bus.FWD_SEL_A); else n_pass++;
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd3) $display("FAIL lu_retry_sel_a: got %0d expected 3", bus.FWD_SEL_A); else n_pass++;
      n_total++; if (bus.FWD_SEL_B !== 3'd3) $display("FAIL lu_retry_sel_b: got %0d expected 3", bus.FWD_SEL_B); else n_pass++;
   endtask

   task automatic test_x0_and_distance();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      #1;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL x0_stall: got %0b expected 0", bus.STALL); else n_pass++;
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL x0_sel_a: got %0d expected 0", bus.FWD_SEL_A); else n_pass++;
      n_total++; if (bus.FWD_SEL_B !== 3'd0) $display("FAIL x0_sel_b: got %0d expected 0", bus.FWD_SEL_B); else n_pass++;

      do_reset();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
      tick(); nop(); tick(); tick();
      set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd4) $display("FAIL dist3_sel_a: got %0d expected 4", bus.FWD_SEL_A); else n_pass++;
      n_total++; if (bus.FWD_SEL_B !== 3'd0) $display("FAIL dist3_unused_sel_b: got %0d expected 0", bus.FWD_SEL_B); else n_pass++;

      do_reset();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
      tick(); nop(); tick(); tick(); tick();
      set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL dist4_sel_a: got %0d expected 0", bus.FWD_SEL_A); else n_pass++;
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      bus.FLUSH = 1'b1;
      #1;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL flush_stall: got %0b expected 0", bus.STALL); else n_pass++;
      tick();
      bus.FLUSH = 1'b0;
      n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL flush_sel_a: got %0d expected 0", bus.FWD_SEL_A); else n_pass++;
      n_total++; if (bus.FWD_SEL_B !== 3'd0) $display("FAIL flush_sel_b: got %0d expected 0", bus.FWD_SEL_B); else n_pass++;
      #1;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL flush_ex_bubble_stall: got %0b expected 0", bus.STALL); else n_pass++;
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd3) $display("FAIL flush_after_sel_a: got %0d expected 3", bus.FWD_SEL_A); else n_pass++;
   endtask

   task automatic test_busy();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      bus.BUSY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++; if (bus.STALL !== 1'b0) $display("FAIL busy_stall_%0d: got %0b expected 0", i, bus.STALL); else n_pass++;
         tick();
         n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL busy_hold_sel_a_%0d: got %0d expected 0", i, bus.FWD_SEL_A); else n_pass++;
      end
      bus.BUSY = 1'b0;
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd1) $display("FAIL busy_release_sel_a: got %0d expected 1", bus.FWD_SEL_A); else n_pass++;

      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
      bus.BUSY = 1'b1;
      #1;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL busy_load_stall: got %0b expected 0", bus.STALL); else n_pass++;
      tick();
      bus.BUSY = 1'b0;
      #1;
      n_total++; if (bus.STALL !== 1'b1) $display("FAIL busy_release_load_stall: got %0b expected 1", bus.STALL); else n_pass++;
      nop();
   endtask

   task automatic test_reset_in_stall();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL rst_stall_during: got %0b expected 0", bus.STALL); else n_pass++;
      tick();
      rst = 1'b0;
      n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL rst_stall_sel_a: got %0d expected 0", bus.FWD_SEL_A); else n_pass++;
      #1;
      n_total++; if (bus.STALL !== 1'b0) $display("FAIL rst_stall_after: got %0b expected 0", bus.STALL); else n_pass++;
      tick();
      nop();
      n_total++; if (bus.FWD_SEL_A !== 3'd0) $display("FAIL rst_empty_shadow_sel_a: got %0d expected 0", bus.FWD_SEL_A); else n_pass++;
   endtask

`ifdef OPERAND_FORWARD_STATS_EN
   task automatic test_stats();
      do_reset();
      n_total++; if (bus.STALL_COUNT !== 32'd0) $display("FAIL stats_reset_stall: got %0d expected 0", bus.STALL_COUNT); else n_pass++;
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      tick(); tick();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
      tick(); tick();
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
      tick();
      nop();
      tick();
      n_total++; if (bus.STALL_COUNT !== 32'd2) $display("FAIL stats_stall_count: got %0d expected 2", bus.STALL_COUNT); else n_pass++;
      n_total++; if (bus.FWD_COUNT !== 32'd3) $display("FAIL stats_fwd_count: got %0d expected 3", bus.FWD_COUNT); else n_pass++;
      do_reset();
      n_total++; if (bus.STALL_COUNT !== 32'd0) $display("FAIL stats_clear_stall: got %0d expected 0", bus.STALL_COUNT); else n_pass++;
      n_total++; if (bus.FWD_COUNT !== 32'd0) $display("FAIL stats_clear_fwd: got %0d expected 0", bus.FWD_COUNT); else n_pass++;
   endtask
`endif

   initial begin
      nop();
      bus.BUSY  = 1'b0;
      bus.FLUSH = 1'b0;
      tick();
      test_reset();
      test_back_to_back();
      test_load_use();
      test_x0_and_distance();
      test_flush();
      test_busy();
      test_reset_in_stall();
`ifdef OPERAND_FORWARD_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
